// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO controller and its output skid buffer.
package fifo_pkg;

  localparam int FIFO_WIDTH = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

  // fifo_ram returns read data one cycle after ram_re.
  localparam int RAM_RD_LAT = 1;

  typedef logic [FIFO_AW-1:0] ptr_t;
  typedef logic [FIFO_AW:0]   cnt_t;

endpackage

// File: rtl/fifo_skid.sv
// Two-entry output buffer that absorbs the RAM read latency and presents the
// queue head with first-word-fall-through semantics.
module fifo_skid
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       occ
);

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             pop;
  logic [1:0]       occ_after_pop;

  // Pop shifts the tail into the head; a write lands in the first free slot after the pop.
  always_comb begin
    pop           = (occ_q != 2'd0) && rd_ready;
    occ_after_pop = occ_q - {1'b0, pop};
    head_d        = head_q;
    tail_d        = tail_q;
    if (pop) begin
      head_d = tail_q;
    end
    if (wr_en) begin
      if (occ_after_pop == 2'd0) begin
        head_d = wr_data;
      end else begin
        tail_d = wr_data;
      end
    end
    occ_d = occ_after_pop + {1'b0, wr_en};
  end

  // Occupancy is control state and is cleared; entry data is left as-is.
  always_ff @(posedge clock) begin
    if (clear) begin
      occ_q <= 2'd0;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clock) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign rd_valid = (occ_q != 2'd0);
  assign rd_data  = head_q;
  assign occ      = occ_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and read-issue controller for the FIFO built around fifo_ram.
// Reads are issued ahead into a two-entry skid buffer so a word can leave every cycle.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter  int WIDTH = FIFO_WIDTH,
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      count,
  output logic             ram_we,
  output logic [AW-1:0]    ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_re,
  output logic [AW-1:0]    ram_raddr,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    skid_occ;
  logic          clear, push, pop, issue;
  logic [2:0]    pending;

  // Handshakes, read issue and next-state arithmetic.
  always_comb begin
    clear    = reset || flush;
    count    = ram_cnt_q + {{AW{1'b0}}, inflight_q} + {{(AW-1){1'b0}}, skid_occ};
    in_ready = !clear && (count < DEPTH_C);
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    // Words that will sit in the skid buffer once this cycle's return and pop settle.
    pending  = {1'b0, skid_occ} + {2'b0, inflight_q};
    // ram_cnt excludes this cycle's push, so a read never targets the word being written.
    issue    = (ram_cnt_q != '0) && !clear && (pending < 3'd2 + {2'b0, pop});

    wr_ptr_d   = wr_ptr_q + {{(AW-1){1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{(AW-1){1'b0}}, issue};
    ram_cnt_d  = ram_cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue};
    inflight_d = issue;

    ram_we    = push;
    ram_waddr = wr_ptr_q;
    ram_wdata = in_data;
    ram_re    = issue;
    ram_raddr = rd_ptr_q;
  end

  // Control state register; reset and flush return everything to empty.
  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Data returning during a reset/flush cycle is dropped by gating the skid write.
  fifo_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clock    (clock),
    .clear    (clear),
    .wr_en    (inflight_q && !clear),
    .wr_data  (ram_rdata),
    .rd_ready (out_ready),
    .rd_valid (out_valid),
    .rd_data  (out_data),
    .occ      (skid_occ)
  );

  // Structural invariants of the controller.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (count <= DEPTH_C);
      assert (!(ram_we && !in_ready));
      assert (skid_occ <= 2'd2);
      assert (!ram_re || (ram_cnt_q != '0));
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl: behavioural fifo_ram, queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  localparam int W   = FIFO_WIDTH;
  localparam int D   = FIFO_DEPTH;
  // A word becomes visible at the output this many cycles after its push, at the earliest.
  localparam int VIS = RAM_RD_LAT + 2;

  logic         clock     = 1'b0;
  logic         reset     = 1'b1;
  logic         flush     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  cnt_t         count;
  logic         ram_we, ram_re;
  ptr_t         ram_waddr, ram_raddr;
  logic [W-1:0] ram_wdata, ram_rdata;
  logic [W-1:0] mem [D];

  typedef struct {
    logic [W-1:0] d;
    int           t;
  } ent_t;

  ent_t q[$];
  int   cyc = 0, wr_k = 0;
  int   tests = 0, fails = 0;
  int   pushes_acc = 0, pops_seen = 0, max_cnt = 0;

  fifo_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_re    (ram_re),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural fifo_ram: synchronous write, one-cycle registered read.
  always @(posedge clock) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance the model.
  task automatic cycle(input logic v, input logic [W-1:0] dat, input logic r,
                       input logic f, input logic rs);
    logic exp_rdy, exp_vld;
    @(negedge clock);
    in_valid  = v;
    in_data   = dat;
    out_ready = r;
    flush     = f;
    reset     = rs;
    #1;
    exp_rdy = !rs && !f && (q.size() < D);
    exp_vld = (q.size() != 0) && (q[0].t + VIS <= cyc);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_vld));
    chk("count", 64'(count), 64'(q.size()));
    chk("ram_we", 64'(ram_we), 64'(v && exp_rdy));
    if (v && exp_rdy) begin
      chk("ram_waddr", 64'(ram_waddr), 64'(wr_k % D));
      chk("ram_wdata", 64'(ram_wdata), 64'(dat));
    end
    if (rs || f) chk("ram_re_clear", 64'(ram_re), 64'(0));
    if (exp_vld && r) chk("out_data", 64'(out_data), 64'(q[0].d));
    if (int'(count) > max_cnt) max_cnt = int'(count);
    if (rs || f) begin
      q.delete();
      wr_k = 0;
    end else begin
      if (exp_vld && r) begin
        void'(q.pop_front());
        pops_seen++;
      end
      if (v && exp_rdy) begin
        q.push_back('{d: dat, t: cyc});
        wr_k++;
        pushes_acc++;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    chk("drain_bound", 64'(q.size()), 64'(0));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    // Reset state.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_ram_re", 64'(ram_re), 64'(0));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_waddr", 64'(ram_waddr), 64'(0));
    chk("post_rst_raddr", 64'(ram_raddr), 64'(0));

    // Four pushes with the consumer stalled, then pop them all.
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(32'hA0 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("a_count", 64'(count), 64'(4));
    chk("a_valid", 64'(out_valid), 64'(1));
    chk("a_head", 64'(out_data), 64'(32'hA0));
    for (int i = 0; i < 4; i++) chk("a_mem", 64'(mem[i]), 64'(32'hA0 + i));
    drain();
    chk("a_empty_valid", 64'(out_valid), 64'(0));

    // Fill to full; extra push is refused; a pop reopens the input next cycle.
    for (int i = 0; i < D; i++) cycle(1'b1, W'(32'hF00 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(32'hDEAD), 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_count", 64'(count), 64'(D));
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("full_pop_no_bypass", 64'(in_ready), 64'(0));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("full_reopen", 64'(in_ready), 64'(1));
    drain();

    // Continuous streaming at full rate.
    max_cnt = 0;
    pops_seen = 0;
    for (int i = 0; i < 100; i++) cycle(1'b1, W'(32'h1000 + i), 1'b1, 1'b0, 1'b0);
    chk("stream_pops", 64'(pops_seen), 64'(97));
    chk("stream_max_le3", 64'(max_cnt <= 3), 64'(1));
    drain();

    // Random traffic with 50% consumer backpressure.
    pushes_acc = 0;
    n = 0;
    while (pushes_acc < 500 && n < 5000) begin
      cycle(1'b1 && ($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 1)),
            1'b0, 1'b0);
      n++;
    end
    chk("rand_pushes", 64'(pushes_acc), 64'(500));
    drain();

    // Flush with five entries held and one read in flight.
    for (int i = 0; i < 6; i++) cycle(1'b1, W'(32'hC0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, W'(32'hBEEF), 1'b0, 1'b1, 1'b0);
    chk("flush_count_before", 64'(count), 64'(5));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_valid", 64'(out_valid), 64'(0));
    cycle(1'b1, W'(32'h55), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("flush_head", 64'(out_data), 64'(32'h55));
    chk("flush_mem0", 64'(mem[0]), 64'(32'h55));
    drain();

    // One-cycle reset in the middle of a stream.
    for (int i = 0; i < 10; i++) cycle(1'b1, W'(32'h2000 + i), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, W'(32'hBAD), 1'b1, 1'b0, 1'b1);
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_count", 64'(count), 64'(0));
    chk("mid_rst_waddr", 64'(ram_waddr), 64'(0));
    chk("mid_rst_raddr", 64'(ram_raddr), 64'(0));
    cycle(1'b1, W'(32'h77), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_head", 64'(out_data), 64'(32'h77));
    chk("mid_rst_mem0", 64'(mem[0]), 64'(32'h77));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
